ac97_sample_bridge: RTL and testbench



---
 rtl/ac97_sample_bridge.sv | 133 +++++++++++++
 tb/tb_ac97_sample_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_sample_bridge.sv
// rtl/ac97_sample_bridge.sv - AC97 frame capture/playback bridge with ingress and egress sample FIFOs
module ac97_sample_bridge #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock_27mhz,
  input  logic             reset_b,
  input  logic             ready,
  input  logic [19:0]      left_in_data,
  input  logic [19:0]      right_in_data,
  input  logic             bypass,
  output logic             in_valid,
  output logic [19:0]      in_left,
  output logic [19:0]      in_right,
  input  logic             in_accept,
  input  logic             proc_valid,
  input  logic [19:0]      proc_left,
  input  logic [19:0]      proc_right,
  output logic             proc_accept,
  output logic [19:0]      left_out_data,
  output logic [19:0]      right_out_data,
  output logic             frame_strobe,
  output logic [CNT_W-1:0] overrun_count,
  output logic [CNT_W-1:0] underrun_count
);

  localparam int AW = $clog2(DEPTH);

  // ready arrives from the bit-clock domain: two flops to resynchronise, a third for edge detection
  logic ready_sync1, ready_sync2, ready_sync3;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0] in_wr_ptr, in_rd_ptr;
  logic [AW:0] eg_wr_ptr, eg_rd_ptr;

  // Each entry is {left, right}
  logic [39:0] in_mem [DEPTH];
  logic [39:0] eg_mem [DEPTH];

  logic in_empty, in_full, eg_empty, eg_full;
  logic in_push, in_pop, eg_push, eg_pop;
  logic overrun_evt, underrun_evt;
  logic [39:0] eg_head;

  assign frame_strobe = ready_sync2 & ~ready_sync3;

  assign in_empty = (in_wr_ptr == in_rd_ptr);
  assign in_full  = (in_wr_ptr[AW] != in_rd_ptr[AW]) &&
                    (in_wr_ptr[AW-1:0] == in_rd_ptr[AW-1:0]);
  assign eg_empty = (eg_wr_ptr == eg_rd_ptr);
  assign eg_full  = (eg_wr_ptr[AW] != eg_rd_ptr[AW]) &&
                    (eg_wr_ptr[AW-1:0] == eg_rd_ptr[AW-1:0]);

  assign in_valid    = ~in_empty;
  assign proc_accept = ~eg_full;
  assign in_left     = in_mem[in_rd_ptr[AW-1:0]][39:20];
  assign in_right    = in_mem[in_rd_ptr[AW-1:0]][19:0];
  assign eg_head     = eg_mem[eg_rd_ptr[AW-1:0]];

  // A full ingress FIFO still takes the new sample if the head leaves in the same cycle
  assign in_pop       = in_valid & in_accept;
  assign in_push      = frame_strobe & (~in_full | in_pop);
  assign overrun_evt  = frame_strobe & in_full & ~in_pop;

  // The egress head is consumed only by a non-bypass frame
  assign eg_push      = proc_valid & proc_accept;
  assign eg_pop       = frame_strobe & ~bypass & ~eg_empty;
  assign underrun_evt = frame_strobe & ~bypass & eg_empty;

  // Resynchronise ready and keep one extra stage for rise detection
  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      ready_sync1 <= 1'b0;
      ready_sync2 <= 1'b0;
      ready_sync3 <= 1'b0;
    end else begin
      ready_sync1 <= ready;
      ready_sync2 <= ready_sync1;
      ready_sync3 <= ready_sync2;
    end
  end

  // FIFO storage needs no reset: pointers alone define which entries are live
  always_ff @(posedge clock_27mhz) begin
    if (in_push) in_mem[in_wr_ptr[AW-1:0]] <= {left_in_data, right_in_data};
    if (eg_push) eg_mem[eg_wr_ptr[AW-1:0]] <= {proc_left, proc_right};
  end

  // Advance FIFO pointers; they wrap naturally modulo twice the depth
  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      eg_wr_ptr <= '0;
      eg_rd_ptr <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
      if (eg_push) eg_wr_ptr <= eg_wr_ptr + 1'b1;
      if (eg_pop)  eg_rd_ptr <= eg_rd_ptr + 1'b1;
    end
  end

  // Saturating debug counters for dropped captures and starved playback frames
  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      overrun_count  <= '0;
      underrun_count <= '0;
    end else begin
      if (overrun_evt && (overrun_count != {CNT_W{1'b1}}))
        overrun_count <= overrun_count + 1'b1;
      if (underrun_evt && (underrun_count != {CNT_W{1'b1}}))
        underrun_count <= underrun_count + 1'b1;
    end
  end

  // Once per frame load the playback registers from the capture (bypass) or the egress head
  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      left_out_data  <= 20'h00000;
      right_out_data <= 20'h00000;
    end else if (frame_strobe) begin
      if (bypass) begin
        left_out_data  <= left_in_data;
        right_out_data <= right_in_data;
      end else if (!eg_empty) begin
        left_out_data  <= eg_head[39:20];
        right_out_data <= eg_head[19:0];
      end
    end
  end

endmodule

// File: tb/tb_ac97_sample_bridge.sv
// tb/tb_ac97_sample_bridge.sv - queue-model bench for ac97_sample_bridge
module tb_ac97_sample_bridge;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clock_27mhz = 1'b0;
  logic             reset_b = 1'b0;
  logic             ready = 1'b0;
  logic [19:0]      left_in_data = '0;
  logic [19:0]      right_in_data = '0;
  logic             bypass = 1'b0;
  logic             in_valid;
  logic [19:0]      in_left, in_right;
  logic             in_accept = 1'b0;
  logic             proc_valid = 1'b0;
  logic [19:0]      proc_left = '0;
  logic [19:0]      proc_right = '0;
  logic             proc_accept;
  logic [19:0]      left_out_data, right_out_data;
  logic             frame_strobe;
  logic [CNT_W-1:0] overrun_count, underrun_count;

  ac97_sample_bridge #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock_27mhz   (clock_27mhz),
    .reset_b       (reset_b),
    .ready         (ready),
    .left_in_data  (left_in_data),
    .right_in_data (right_in_data),
    .bypass        (bypass),
    .in_valid      (in_valid),
    .in_left       (in_left),
    .in_right      (in_right),
    .in_accept     (in_accept),
    .proc_valid    (proc_valid),
    .proc_left     (proc_left),
    .proc_right    (proc_right),
    .proc_accept   (proc_accept),
    .left_out_data (left_out_data),
    .right_out_data(right_out_data),
    .frame_strobe  (frame_strobe),
    .overrun_count (overrun_count),
    .underrun_count(underrun_count)
  );

  always #5 clock_27mhz = ~clock_27mhz;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, frames as "two edges after ready is first seen high"
  logic [39:0] ing_q[$];
  logic [39:0] eg_q[$];
  logic [19:0] m_l = '0, m_r = '0;
  int          m_ovr = 0, m_und = 0;
  int          cyc = 0, rise_at = -100;
  logic        prev_rdy = 1'b0, exp_strobe = 1'b0;
  logic        m_strobe, m_pop_in, m_ing_full, m_eg_room;

  always @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      ing_q.delete();
      eg_q.delete();
      m_l = '0; m_r = '0;
      m_ovr = 0; m_und = 0;
      cyc = 0; rise_at = -100;
      prev_rdy = 1'b0; exp_strobe = 1'b0;
    end else begin
      cyc++;
      m_strobe   = exp_strobe;
      m_pop_in   = in_accept && (ing_q.size() > 0);
      m_ing_full = (ing_q.size() == DEPTH);
      if (m_pop_in) void'(ing_q.pop_front());
      if (m_strobe) begin
        if (!m_ing_full || m_pop_in) ing_q.push_back({left_in_data, right_in_data});
        else if (m_ovr < SAT) m_ovr++;
      end
      m_eg_room = (eg_q.size() < DEPTH);
      if (m_strobe) begin
        if (bypass) begin
          m_l = left_in_data; m_r = right_in_data;
        end else if (eg_q.size() > 0) begin
          {m_l, m_r} = eg_q.pop_front();
        end else if (m_und < SAT) begin
          m_und++;
        end
      end
      if (proc_valid && m_eg_room) eg_q.push_back({proc_left, proc_right});
      if (ready && !prev_rdy) rise_at = cyc;
      prev_rdy = ready;
      exp_strobe = (cyc == rise_at + 1);
    end
  end

  // Every cycle out of reset, compare the DUT against the model
  always @(negedge clock_27mhz) begin
    if (reset_b) begin
      chk("frame_strobe", 40'(frame_strobe), 40'(exp_strobe));
      chk("in_valid", 40'(in_valid), 40'(ing_q.size() > 0));
      if (ing_q.size() > 0) chk("in_head", {in_left, in_right}, ing_q[0]);
      chk("proc_accept", 40'(proc_accept), 40'(eg_q.size() < DEPTH));
      chk("out_data", {left_out_data, right_out_data}, {m_l, m_r});
      chk("overrun_count", 40'(overrun_count), 40'(m_ovr));
      chk("underrun_count", 40'(underrun_count), 40'(m_und));
    end
  end

  task automatic step();
    @(posedge clock_27mhz);
    #1;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    ready = 1'b0;
    in_accept = 1'b0;
    proc_valid = 1'b0;
    step();
    step();
    reset_b = 1'b1;
  endtask

  task automatic frame(input logic [19:0] l, input logic [19:0] r);
    left_in_data = l;
    right_in_data = r;
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic push_eg(input logic [19:0] l, input logic [19:0] r);
    proc_left = l;
    proc_right = r;
    proc_valid = 1'b1;
    step();
    proc_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  int exp_k[4];
  int gap, hi_cnt;

  initial begin
    // Reset values
    bypass = 1'b1;
    do_reset();
    @(negedge clock_27mhz);
    chk("rst_out", {left_out_data, right_out_data}, 40'h0);
    chk("rst_in_valid", 40'(in_valid), 40'h0);
    chk("rst_proc_accept", 40'(proc_accept), 40'h1);
    chk("rst_counts", 40'({overrun_count, underrun_count}), 40'h0);
    chk("rst_strobe", 40'(frame_strobe), 40'h0);

    // Strobe is high only in the cycle ending at the 3rd edge after ready rises
    ready = 1'b1;
    step();
    @(negedge clock_27mhz);
    chk("strobe_e1", 40'(frame_strobe), 40'h0);
    step();
    ready = 1'b0;
    @(negedge clock_27mhz);
    chk("strobe_e2", 40'(frame_strobe), 40'h1);
    step();
    @(negedge clock_27mhz);
    chk("strobe_e3", 40'(frame_strobe), 40'h0);

    // Single capture visible at the ingress head, then popped
    do_reset();
    frame(20'h12345, 20'hABCDE);
    @(negedge clock_27mhz);
    chk("cap_valid", 40'(in_valid), 40'h1);
    chk("cap_head", {in_left, in_right}, {20'h12345, 20'hABCDE});
    in_accept = 1'b1;
    step();
    in_accept = 1'b0;
    @(negedge clock_27mhz);
    chk("cap_popped", 40'(in_valid), 40'h0);

    // Six frames into a 4-deep ingress FIFO: two overruns, first four kept
    do_reset();
    for (int k = 1; k <= 6; k++) frame(20'(k), 20'(k + 'h100));
    @(negedge clock_27mhz);
    chk("ovr_count", 40'(overrun_count), 40'h2);
    chk("ovr_head", {in_left, in_right}, {20'h00001, 20'h00101});
    // Full FIFO with a pop on the strobe cycle accepts the new sample
    left_in_data = 20'h00007;
    right_in_data = 20'h00107;
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    in_accept = 1'b1;
    step();
    in_accept = 1'b0;
    step();
    @(negedge clock_27mhz);
    chk("ovr_simpop_count", 40'(overrun_count), 40'h2);
    exp_k = '{2, 3, 4, 7};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_27mhz);
      chk("ovr_order", {in_left, in_right}, {20'(exp_k[i]), 20'(exp_k[i] + 'h100)});
      in_accept = 1'b1;
      step();
      in_accept = 1'b0;
    end
    @(negedge clock_27mhz);
    chk("ovr_drained", 40'(in_valid), 40'h0);

    // Egress playback, then underrun holds the last value
    bypass = 1'b0;
    do_reset();
    push_eg(20'h00001, 20'h00002);
    frame(20'hAAAAA, 20'hBBBBB);
    @(negedge clock_27mhz);
    chk("play_out", {left_out_data, right_out_data}, {20'h00001, 20'h00002});
    chk("play_und0", 40'(underrun_count), 40'h0);
    frame(20'hCCCCC, 20'hDDDDD);
    @(negedge clock_27mhz);
    chk("hold_out", {left_out_data, right_out_data}, {20'h00001, 20'h00002});
    chk("hold_und1", 40'(underrun_count), 40'h1);

    // Bypass routes the capture and leaves the egress entry in place
    push_eg(20'h00055, 20'h00066);
    bypass = 1'b1;
    frame(20'h7FFFF, 20'h80000);
    @(negedge clock_27mhz);
    chk("byp_out", {left_out_data, right_out_data}, {20'h7FFFF, 20'h80000});
    bypass = 1'b0;
    frame(20'h0, 20'h0);
    @(negedge clock_27mhz);
    chk("byp_kept", {left_out_data, right_out_data}, {20'h00055, 20'h00066});
    chk("byp_und", 40'(underrun_count), 40'h1);

    // Egress full back-pressure and counter saturation
    do_reset();
    in_accept = 1'b1;
    proc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      proc_left = 20'('h100 + i);
      proc_right = 20'('h200 + i);
      step();
    end
    @(negedge clock_27mhz);
    chk("eg_three", 40'(proc_accept), 40'h1);
    proc_left = 20'h00103;
    proc_right = 20'h00203;
    step();
    proc_valid = 1'b0;
    @(negedge clock_27mhz);
    chk("eg_full", 40'(proc_accept), 40'h0);
    frame(20'h0, 20'h0);
    @(negedge clock_27mhz);
    chk("eg_pop_out", {left_out_data, right_out_data}, {20'h00100, 20'h00200});
    chk("eg_pop_accept", 40'(proc_accept), 40'h1);
    for (int i = 0; i < 8; i++) frame(20'h0, 20'h0);
    @(negedge clock_27mhz);
    chk("und_sat", 40'(underrun_count), 40'h3);
    chk("und_last", {left_out_data, right_out_data}, {20'h00103, 20'h00203});
    in_accept = 1'b0;

    // Randomized traffic with one mid-run reset
    do_reset();
    gap = 2;
    hi_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        reset_b = 1'b0;
        ready = 1'b0;
        hi_cnt = 0;
        gap = 3;
        step();
        reset_b = 1'b1;
      end
      in_accept = 1'($urandom_range(0, 1));
      proc_valid = 1'($urandom_range(0, 1));
      proc_left = 20'($urandom);
      proc_right = 20'($urandom);
      if (hi_cnt > 0) begin
        hi_cnt--;
        if (hi_cnt == 0) ready = 1'b0;
      end
      if (gap == 0) begin
        ready = 1'b1;
        left_in_data = 20'($urandom);
        right_in_data = 20'($urandom);
        bypass = ($urandom_range(0, 3) == 0);
        hi_cnt = 2;
        gap = $urandom_range(3, 9);
      end else begin
        gap--;
      end
      step();
    end
    in_accept = 1'b0;
    proc_valid = 1'b0;
    ready = 1'b0;
    step();
    @(negedge clock_27mhz);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
